dmem_debug_master: RTL and testbench
====================================

# dmem_debug_master

Debug-side initiator for the data memory's second (debug) port. It accepts burst read/write commands over a valid/ready handshake and drives the port's word address, write data and byte-write-enable signals. It compensates for the memory's one-cycle synchronous read latency and returns read words over a backpressured response stream. It sits between the debug/host command logic and the data-memory debug port (A2/WD2/WE2/RD2) of the write-back segment.

## Interface
- No parameters. Response FIFO depth is fixed at 4; the burst-length field is 8 bits.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  byte start address; bits [1:0] ignored, treated as 00
- cmd_len  in  8  beats minus one (0 → 1 word, 255 → 256 words)
- cmd_be  in  4  byte-write mask applied to every write beat
- wd_valid  in  1  write-data beat offered
- wd_ready  out  1  write-data beat accepted
- wd_data  in  32  write-data word
- rsp_valid  out  1  read word available
- rsp_ready  in  1  read word consumed
- rsp_data  out  32  read word
- rsp_last  out  1  marks the final word of a read burst
- A2  out  32  debug-port byte address (memory uses A2[31:2])
- WD2  out  32  debug-port write data
- WE2  out  4  debug-port byte write enable
- RD2  in  32  debug-port read data, valid the cycle after its address
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- **IDLE**
  - cmd_ready = 1.
  - On accept, latch addr = {cmd_addr[31:2], 2'b00}, remaining = cmd_len, be = cmd_be.
  - Go to WRITE if cmd_write = 1, else READ.
- **WRITE**
  - wd_ready = 1.
  - WE2 = wd_valid ? be : 4'b0000; WD2 = wd_data; A2 = addr. All three are combinational.
  - Each accepted beat: addr += 4; remaining -= 1.
  - Beat accepted with remaining = 0 → IDLE, done pulses the next cycle.
  - wd_valid low: WE2 = 0, no state change.
- **READ**
  - WE2 = 0; A2 = addr.
  - A read is issued in any cycle where fifo_count + inflight < 4. An issue sets inflight = 1 for the next cycle, then addr += 4 and remaining -= 1.
  - Issue with remaining = 0 → DRAIN. The issue carries a last tag.
  - inflight = 1 → RD2 and its last tag are pushed into the response FIFO at that cycle's edge.
- **DRAIN**
  - No issues.
  - fifo_count = 0 and inflight = 0 → IDLE, done pulses the next cycle.
- **Response FIFO**
  - 4 entries of {last, data[31:0]}.
  - rsp_valid = (count ≠ 0); rsp_data and rsp_last come from the head.
  - Push and pop in the same cycle leave count unchanged.
  - The credit rule above guarantees overflow never occurs.
- **Address arithmetic**: 32-bit modulo; 0xFFFFFFFC + 4 = 0x00000000.
- **Idle port values**: WE2 = 0 and WD2 = 0 in IDLE, READ and DRAIN. A2 holds the last addr.
- cmd_valid is ignored outside IDLE.

## Timing
- **Reset values** (asynchronous reset): state IDLE, cmd_ready 1 once rst deasserts (0 while rst high), wd_ready 0, rsp_valid 0, rsp_last 0, rsp_data 0, A2 0, WD2 0, WE2 0, busy 0, done 0. FIFO emptied, inflight cleared.
- **Reset mid-burst**: the burst is abandoned, no done pulse, and queued FIFO data is discarded. A write beat being presented in the reset cycle is not guaranteed written.
- **Write latency**: accept in cycle C → first WE2 assertion possible in C+1. One beat per cycle while wd_valid is held high.
- **Read latency**: accept in cycle C → first issue in C+1 → RD2 valid in C+2 → rsp_valid high in C+3.
- **Read throughput**: with rsp_ready held high, one word per cycle sustained with no bubbles.
- **Backpressure**: with rsp_ready low, at most 4 words are outstanding, then issue stalls. rsp_data and rsp_last stay stable while rsp_valid is high and rsp_ready is low.
- **done**: asserts exactly one cycle, in the cycle state returns to IDLE. A new command can be accepted in that same cycle.

## Test plan
- **Single write then read**: write addr 0x10, len 0, be 4'hF, data 0xDEADBEEF, then read addr 0x10 len 0. Required: WE2 = F with A2 = 0x10 for one cycle; response 0xDEADBEEF with rsp_last = 1 in C+3; one done pulse per burst.
- **Burst read, full throughput**: preload words 0x20..0x2C with 1..4; read 0x23 (low bits ignored) len 3, rsp_ready = 1. Required: rsp_data 1,2,3,4 on consecutive cycles starting C+3; rsp_last on the 4th word only.
- **Backpressure**: read len 7 with rsp_ready = 0 for 10 cycles, then 1. Required: exactly 4 issues before stall, no lost or duplicated words, 8 words returned in order.
- **Partial byte write with gaps**: write 0x40 len 1, be 4'b0011, wd_valid toggling 1,0,1. Required: WE2 = 4'b0011 only on the beat cycles at A2 = 0x40 then 0x44; WE2 = 0 in the gap cycle.
- **Address wrap**: read addr 0xFFFFFFFC len 1. Required: A2 sequence 0xFFFFFFFC, 0x00000000.
- **Reset mid-read**: assert rst while 2 words are queued in the FIFO. Required: rsp_valid = 0, busy = 0, WE2 = 0 immediately, no done pulse; a new command is accepted after rst deasserts.

Source files
------------

// File: rtl/dmem_debug_master_if.sv
// Bundle between the debug command logic, the debug master and the
// data-memory debug port (A2/WD2/WE2/RD2).
interface dmem_debug_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_be;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [31:0] A2;
    logic [31:0] WD2;
    logic [3:0]  WE2;
    logic [31:0] RD2;
    logic        busy;
    logic        done;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
        output cmd_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output A2, WD2, WE2,
        input  RD2,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
        input  cmd_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  A2, WD2, WE2,
        output RD2,
        input  busy, done
    );
endinterface

// File: rtl/dmem_debug_master.sv
// Burst initiator for the data-memory debug port with read-latency
// compensation and a 4-entry credit-limited response FIFO.
module dmem_debug_master (
    input  logic                 clk,
    input  logic                 rst,
    dmem_debug_master_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [7:0]  remaining;
    logic [3:0]  be;
    logic        inflight;
    logic        inflight_last;
    logic        done_q;

    logic [32:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic        beat_fire;
    logic        issue;
    logic        push;
    logic        pop;
    logic [2:0]  credit_used;
    logic [32:0] head;

    assign beat_fire   = (state == WRITE) && bus.wd_valid;
    assign credit_used = count + {2'b00, inflight};
    assign issue       = (state == READ) && (credit_used < 3'd4);
    assign push        = inflight;
    assign pop         = (count != 3'd0) && bus.rsp_ready;
    assign head        = fifo_mem[rd_ptr];

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.wd_ready  = (state == WRITE);
    assign bus.WE2       = beat_fire ? be : 4'b0000;
    assign bus.WD2       = (state == WRITE) ? bus.wd_data : 32'h0;
    assign bus.A2        = addr;
    assign bus.rsp_valid = (count != 3'd0);
    assign bus.rsp_data  = bus.rsp_valid ? head[31:0] : 32'h0;
    assign bus.rsp_last  = bus.rsp_valid ? head[32] : 1'b0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

    // Burst sequencing: latch command, step address per beat/issue, finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= 32'h0;
            remaining     <= 8'h0;
            be            <= 4'h0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == 8'd0);
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr      <= bus.cmd_addr & 32'hFFFF_FFFC;
                        remaining <= bus.cmd_len;
                        be        <= bus.cmd_be;
                        state     <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (bus.wd_valid) begin
                        addr      <= addr + 32'd4;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr      <= addr + 32'd4;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count == 3'd0 && !inflight) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response FIFO pointers and occupancy; push/pop together holds count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage; RD2 arrives the cycle after its issue.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {inflight_last, bus.RD2};
        end
    end
endmodule

// File: tb/tb_dmem_debug_master.sv
// Randomized bench for dmem_debug_master: synchronous RAM on the debug
// port, shadow word memory as reference, per-scenario tasks.
module tb_dmem_debug_master;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dmem_debug_master_if bus ();

    dmem_debug_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram    [int unsigned];
    logic [31:0] shadow [int unsigned];
    logic [3:0]  we_s;
    logic [31:0] a_s;
    logic [31:0] wd_s;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        int unsigned idx = a[31:2];
        if (ram.exists(idx)) return ram[idx];
        return 32'h0;
    endfunction

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        int unsigned idx = a[31:2];
        if (shadow.exists(idx)) return shadow[idx];
        return 32'h0;
    endfunction

    function automatic void sh_wr(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] m);
        logic [31:0] w;
        int unsigned idx = a[31:2];
        w = sh_rd(a);
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        shadow[idx] = w;
    endfunction

    // Capture port values well after any input or state change.
    always @(negedge clk) begin
        #2;
        we_s = bus.WE2;
        a_s  = bus.A2;
        wd_s = bus.WD2;
    end

    // Synchronous RAM: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin : ram_blk
        logic [31:0] w;
        bus.RD2 <= ram_rd(a_s);
        if (we_s != 4'h0) begin
            w = ram_rd(a_s);
            for (int b = 0; b < 4; b++)
                if (we_s[b]) w[8*b +: 8] = wd_s[8*b +: 8];
            ram[a_s[31:2]] = w;
        end
    end

    task automatic send_cmd(input bit wr, input logic [31:0] a,
                            input logic [7:0] len, input logic [3:0] be,
                            input bit now);
        if (!now) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        bus.cmd_be    = be;
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b want 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_write = ($urandom_range(0, 1) == 1);
    endtask

    // mode 0: wd_valid held high, 1: random gaps, 2: alternate 1,0,1...
    task automatic write_burst(input logic [31:0] a, input logic [7:0] len,
                               input logic [3:0] be, input int mode,
                               input bit use_fix, input logic [31:0] fixd);
        int k = 0;
        int cyc = 0;
        bit v;
        logic [31:0] d;
        logic [31:0] ea;
        logic [31:0] a_al = {a[31:2], 2'b00};
        send_cmd(1'b1, a, len, be, 1'b0);
        while (k <= int'(len) && cyc < 2000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = ($urandom_range(0, 1) == 1);
            else v = (cyc % 2 == 0);
            d = use_fix ? fixd + 32'(k) : $urandom;
            bus.wd_valid = v;
            bus.wd_data  = d;
            #1;
            ea = a_al + 32'(4 * k);
            n_tests++;
            if (bus.WE2 !== (v ? be : 4'h0) || (v && bus.A2 !== ea) ||
                (v && bus.WD2 !== d) || bus.wd_ready !== 1'b1 ||
                bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL write_beat: WE2=%h A2=%h WD2=%h wd_ready=%b done=%b want WE2=%h A2=%h WD2=%h 1 0",
                         bus.WE2, bus.A2, bus.WD2, bus.wd_ready, bus.done,
                         v ? be : 4'h0, ea, d);
            end
            if (v) begin
                sh_wr(ea, d, be);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.wd_valid = 1'b0;
        #1;
        n_tests++;
        if (cyc >= 2000 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
            bus.cmd_ready !== 1'b1 || bus.WE2 !== 4'h0) begin
            n_fail++;
            $display("FAIL write_done: done=%b busy=%b cmd_ready=%b WE2=%h cyc=%0d want 1 0 1 0",
                     bus.done, bus.busy, bus.cmd_ready, bus.WE2, cyc);
        end
    endtask

    // mode 0: rsp_ready high, 1: random, 2: low 10 cycles then high.
    task automatic read_burst(input logic [31:0] a, input logic [7:0] len,
                              input int mode, input bit chk_lat,
                              input bit now);
        int k = 0;
        int cyc = 0;
        int first = -1;
        int prev_pop = -1;
        bit r;
        bit got_done = 1'b0;
        bit held = 1'b0;
        logic [31:0] held_d;
        logic held_l;
        logic [31:0] exp_d;
        logic [31:0] a_al = {a[31:2], 2'b00};
        send_cmd(1'b0, a, len, $urandom_range(0, 15), now);
        while (!got_done && cyc < 3000) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = ($urandom_range(0, 3) != 0);
            else r = (cyc >= 10);
            bus.rsp_ready = r;
            #1;
            n_tests++;
            if (bus.WE2 !== 4'h0 || bus.WD2 !== 32'h0 || bus.wd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL read_port_idle: WE2=%h WD2=%h wd_ready=%b want 0 0 0",
                         bus.WE2, bus.WD2, bus.wd_ready);
            end
            if (mode == 0 && cyc <= int'(len)) begin
                n_tests++;
                if (bus.A2 !== a_al + 32'(4 * cyc)) begin
                    n_fail++;
                    $display("FAIL rd_addr: A2=%h want %h", bus.A2,
                             a_al + 32'(4 * cyc));
                end
            end
            if (mode == 2 && cyc == 10) begin
                n_tests++;
                if (bus.A2 !== a_al + 32'd16 || bus.rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stall: A2=%h rsp_valid=%b want %h 1",
                             bus.A2, bus.rsp_valid, a_al + 32'd16);
                end
            end
            if (held) begin
                n_tests++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held_d ||
                    bus.rsp_last !== held_l) begin
                    n_fail++;
                    $display("FAIL rsp_hold: valid=%b data=%h last=%b want 1 %h %b",
                             bus.rsp_valid, bus.rsp_data, bus.rsp_last,
                             held_d, held_l);
                end
            end
            held = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                if (first < 0) first = cyc;
                if (r) begin
                    exp_d = sh_rd(a_al + 32'(4 * k));
                    n_tests++;
                    if (bus.rsp_data !== exp_d ||
                        bus.rsp_last !== (k == int'(len))) begin
                        n_fail++;
                        $display("FAIL rsp_data: word %0d data=%h last=%b want %h %b",
                                 k, bus.rsp_data, bus.rsp_last, exp_d,
                                 k == int'(len));
                    end
                    if (mode == 0 && k > 0) begin
                        n_tests++;
                        if (cyc != prev_pop + 1) begin
                            n_fail++;
                            $display("FAIL throughput: word %0d at cycle %0d want %0d",
                                     k, cyc, prev_pop + 1);
                        end
                    end
                    prev_pop = cyc;
                    k++;
                end else begin
                    held   = 1'b1;
                    held_d = bus.rsp_data;
                    held_l = bus.rsp_last;
                end
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                n_tests++;
                if (k != int'(len) + 1 || bus.cmd_ready !== 1'b1 ||
                    bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_done: words=%0d cmd_ready=%b busy=%b want %0d 1 0",
                             k, bus.cmd_ready, bus.busy, int'(len) + 1);
                end
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL read_timeout: words=%0d want %0d", k, int'(len) + 1);
        end
        if (chk_lat) begin
            n_tests++;
            if (first != 2) begin
                n_fail++;
                $display("FAIL read_latency: first rsp at C+%0d want C+3", first + 1);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b0 || bus.wd_ready !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0 ||
            bus.rsp_data !== 32'h0 || bus.A2 !== 32'h0 ||
            bus.WD2 !== 32'h0 || bus.WE2 !== 4'h0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: cr=%b wr=%b rv=%b rl=%b rd=%h A2=%h WD2=%h WE2=%h busy=%b done=%b want all 0",
                     bus.cmd_ready, bus.wd_ready, bus.rsp_valid, bus.rsp_last,
                     bus.rsp_data, bus.A2, bus.WD2, bus.WE2, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b want 1 0",
                     bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_single;
        write_burst(32'h10, 8'd0, 4'hF, 0, 1'b1, 32'hDEADBEEF);
        read_burst(32'h10, 8'd0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_burst_read;
        write_burst(32'h20, 8'd3, 4'hF, 0, 1'b1, 32'h1);
        read_burst(32'h23, 8'd3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        write_burst(32'h80, 8'd7, 4'hF, 1, 1'b0, 32'h0);
        read_burst(32'h80, 8'd7, 2, 1'b0, 1'b0);
    endtask

    task automatic test_partial;
        write_burst(32'h40, 8'd1, 4'hF, 0, 1'b1, 32'h11223344);
        write_burst(32'h40, 8'd1, 4'b0011, 2, 1'b0, 32'h0);
        read_burst(32'h40, 8'd1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        write_burst(32'hFFFF_FFFC, 8'd1, 4'hF, 0, 1'b0, 32'h0);
        read_burst(32'hFFFF_FFFC, 8'd1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        write_burst(32'h200, 8'd2, 4'hF, 1, 1'b0, 32'h0);
        read_burst(32'h200, 8'd2, 0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_read;
        send_cmd(1'b0, 32'h20, 8'd7, 4'h0, 1'b0);
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== sh_rd(32'h20)) begin
            n_fail++;
            $display("FAIL mid_read_queued: rsp_valid=%b data=%h want 1 %h",
                     bus.rsp_valid, bus.rsp_data, sh_rd(32'h20));
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.WE2 !== 4'h0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_read_reset: rsp_valid=%b busy=%b WE2=%h cmd_ready=%b want 0 0 0 0",
                     bus.rsp_valid, bus.busy, bus.WE2, bus.cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet: done=%b busy=%b rsp_valid=%b want 0 0 0",
                         bus.done, bus.busy, bus.rsp_valid);
            end
            @(negedge clk);
        end
        read_burst(32'h20, 8'd3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [7:0]  len;
        for (int i = 0; i < 16; i++) begin
            a   = 32'h1000 + 32'($urandom_range(0, 63) * 4) +
                  32'($urandom_range(0, 3));
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                write_burst(a, len, 4'($urandom_range(0, 15)),
                            int'($urandom_range(0, 1)), 1'b0, 32'h0);
            else
                read_burst(a, len, int'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        read_burst(32'h1000, 8'd255, 1, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_len   = 8'h0;
        bus.cmd_be    = 4'h0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = 32'h0;
        bus.rsp_ready = 1'b0;
        test_reset;
        test_single;
        test_burst_read;
        test_backpressure;
        test_partial;
        test_wrap;
        test_back_to_back;
        test_reset_mid_read;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
